// File: rtl/arcade_video_timing.sv
// arcade_video_timing: 15 kHz arcade CRT timing (pixel enable, beam counters, blanking, syncs, csync).
// Define ARCADE_CSYNC_XOR_EN to build csync as ~(hsync ^ vsync) instead of ~(hsync | vsync).
module arcade_video_timing #(
  parameter int CLK_DIV  = 4,
  parameter int CNT_W    = 9,
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 80,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             csync,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic pix_ce_q, pix_ce_d;
  logic hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, csync_q, csync_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic h_wrap, v_wrap;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_ce_d = (div_d == DIV_LAST);
    h_wrap   = (hcount_q == CNT_W'(H_TOTAL - 1));
    v_wrap   = (vcount_q == CNT_W'(V_TOTAL - 1));
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_ce_q) begin
      hcount_d = h_wrap ? '0 : hcount_q + CNT_W'(1);
      if (h_wrap) vcount_d = v_wrap ? '0 : vcount_q + CNT_W'(1);
    end
    line_start_d  = pix_ce_q & h_wrap;
    frame_start_d = line_start_d & v_wrap;
    // Flags decode the next counter values so they line up with hcount/vcount.
    hblank_d = (hcount_d >= CNT_W'(H_ACTIVE));
    vblank_d = (vcount_d >= CNT_W'(V_ACTIVE));
    de_d     = ~hblank_d & ~vblank_d;
    hsync_d  = (hcount_d >= CNT_W'(HS_FIRST)) && (hcount_d <= CNT_W'(HS_LAST));
    vsync_d  = (vcount_d >= CNT_W'(VS_FIRST)) && (vcount_d <= CNT_W'(VS_LAST));
`ifdef ARCADE_CSYNC_XOR_EN
    csync_d  = ~(hsync_d ^ vsync_d);
`else
    csync_d  = ~(hsync_d | vsync_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      pix_ce_q      <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      de_q          <= 1'b1;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      csync_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      pix_ce_q      <= pix_ce_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      csync_q       <= csync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign csync       = csync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_arcade_video_timing.sv
// Bench for arcade_video_timing: default, reduced and CLK_DIV=1 instances share clk/reset;
// a cycle model feeds a scoreboard queue, and per-feature tasks check periods and windows.
module tb_arcade_video_timing;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  // default instance (d_), reduced instance (s_), CLK_DIV=1 instance (u_)
  logic d_pix, d_hb, d_vb, d_de, d_hs, d_vs, d_cs, d_ls, d_fs;
  logic [8:0] d_hc, d_vc;
  logic s_pix, s_hb, s_vb, s_de, s_hs, s_vs, s_cs, s_ls, s_fs;
  logic [7:0] s_hc, s_vc;
  logic u_pix, u_hb, u_vb, u_de, u_hs, u_vs, u_cs, u_ls, u_fs;
  logic [3:0] u_hc, u_vc;

  arcade_video_timing dut (
    .clk(clk), .reset(reset), .pix_ce(d_pix), .hcount(d_hc), .vcount(d_vc),
    .hblank(d_hb), .vblank(d_vb), .de(d_de), .hsync(d_hs), .vsync(d_vs),
    .csync(d_cs), .line_start(d_ls), .frame_start(d_fs));

  arcade_video_timing #(.CLK_DIV(2), .CNT_W(8), .H_ACTIVE(120), .H_FP(4), .H_SYNC(8), .H_BP(12),
    .V_ACTIVE(48), .V_FP(4), .V_SYNC(3), .V_BP(5)) dut_s (
    .clk(clk), .reset(reset), .pix_ce(s_pix), .hcount(s_hc), .vcount(s_vc),
    .hblank(s_hb), .vblank(s_vb), .de(s_de), .hsync(s_hs), .vsync(s_vs),
    .csync(s_cs), .line_start(s_ls), .frame_start(s_fs));

  arcade_video_timing #(.CLK_DIV(1), .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)) dut_u (
    .clk(clk), .reset(reset), .pix_ce(u_pix), .hcount(u_hc), .vcount(u_vc),
    .hblank(u_hb), .vblank(u_vb), .de(u_de), .hsync(u_hs), .vsync(u_vs),
    .csync(u_cs), .line_start(u_ls), .frame_start(u_fs));

  // Expected outputs in clk n, where n counts non-reset edges since the last reset edge.
  function automatic logic [28:0] model(int D, int HA, int HF, int HS, int HB,
                                        int VA, int VF, int VS, int VB, int n);
    int h_tot, v_tot, p, hc, vc;
    bit pix, hb, vb, de, hs, vs, cs, ls, fs;
    h_tot = HA + HF + HS + HB;
    v_tot = VA + VF + VS + VB;
    if (D == 1) begin
      p = (n > 0) ? n - 1 : 0;
      pix = (n > 0);
    end else begin
      p = n / D;
      pix = ((n % D) == D - 1);
    end
    hc = p % h_tot;
    vc = (p / h_tot) % v_tot;
    hb = (hc >= HA);
    vb = (vc >= VA);
    de = !hb && !vb;
    hs = (hc >= HA + HF) && (hc < HA + HF + HS);
    vs = (vc >= VA + VF) && (vc < VA + VF + VS);
`ifdef ARCADE_CSYNC_XOR_EN
    cs = !(hs ^ vs);
`else
    cs = !(hs || vs);
`endif
    ls = (p > 0) && (hc == 0) && (D == 1 || (n % D) == 0);
    fs = ls && (vc == 0);
    return {pix, 10'(hc), 10'(vc), hb, vb, de, hs, vs, cs, ls, fs};
  endfunction

  typedef struct {
    logic [28:0] d;
    logic [28:0] s;
    logic [28:0] u;
  } exp_t;
  exp_t sb[$];
  int n = 0;
  bit model_on = 1'b0;

  // Model: push expectations for the state each edge produces.
  always @(posedge clk) begin
    exp_t e;
    if (reset || model_on) begin
      e.d = model(4, 256, 16, 32, 80, 224, 8, 3, 29, reset ? 0 : n + 1);
      e.s = model(2, 120, 4, 8, 12, 48, 4, 3, 5, reset ? 0 : n + 1);
      e.u = model(1, 8, 2, 3, 3, 4, 1, 1, 2, reset ? 0 : n + 1);
      sb.push_back(e);
    end
    model_on <= model_on | reset;
    n <= reset ? 0 : n + 1;
  end

  // Scoreboard: pop and compare away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    logic [28:0] ad, as_, au;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      ad  = {d_pix, 10'(d_hc), 10'(d_vc), d_hb, d_vb, d_de, d_hs, d_vs, d_cs, d_ls, d_fs};
      as_ = {s_pix, 10'(s_hc), 10'(s_vc), s_hb, s_vb, s_de, s_hs, s_vs, s_cs, s_ls, s_fs};
      au  = {u_pix, 10'(u_hc), 10'(u_vc), u_hb, u_vb, u_de, u_hs, u_vs, u_cs, u_ls, u_fs};
      total += 3;
      if (ad !== e.d) begin
        bad++;
        $display("FAIL sb_default n=%0d got=%h exp=%h", n, ad, e.d);
      end
      if (as_ !== e.s) begin
        bad++;
        $display("FAIL sb_small n=%0d got=%h exp=%h", n, as_, e.s);
      end
      if (au !== e.u) begin
        bad++;
        $display("FAIL sb_div1 n=%0d got=%h exp=%h", n, au, e.u);
      end
    end
  end

  task automatic test_reset();
    int k;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({d_hc, d_vc, d_cs, d_de, d_pix, d_ls, d_fs} !== {9'd0, 9'd0, 5'b11000}) begin
      bad++;
      $display("FAIL reset_state got hc=%0d vc=%0d cs=%b de=%b pix=%b ls=%b fs=%b exp 0 0 1 1 0 0 0",
               d_hc, d_vc, d_cs, d_de, d_pix, d_ls, d_fs);
    end
    reset = 1'b0;
    // clk 1 is the first clk after the last reset edge
    k = 1;
    while (!d_pix && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== 4) begin
      bad++;
      $display("FAIL first_pix_ce got clk %0d exp clk 4", k);
    end
  endtask

  task automatic test_line();
    int k, per, first_hb, hs_lo, hs_hi, last_pix;
    k = 0;
    while (!d_ls && k < 2000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!d_ls) begin
      bad++;
      $display("FAIL line_start_timeout got none exp pulse");
    end
    per = 0; first_hb = -1; hs_lo = -1; hs_hi = -1; last_pix = -1;
    do begin
      @(negedge clk);
      per++;
      if (d_pix) begin
        if (last_pix >= 0) begin
          total++;
          if (per - last_pix !== 4) begin
            bad++;
            $display("FAIL pix_ce_period got %0d exp 4", per - last_pix);
          end
        end
        last_pix = per;
      end
      if (d_hb && first_hb < 0) first_hb = d_hc;
      if (d_hs) begin
        if (hs_lo < 0) hs_lo = d_hc;
        hs_hi = d_hc;
      end
    end while (!d_ls && per < 2000);
    total++;
    if (per !== 1536) begin
      bad++;
      $display("FAIL line_period got %0d exp 1536", per);
    end
    total++;
    if (first_hb !== 256) begin
      bad++;
      $display("FAIL hblank_rise got %0d exp 256", first_hb);
    end
    total++;
    if (hs_lo !== 272 || hs_hi !== 303) begin
      bad++;
      $display("FAIL hsync_window got %0d..%0d exp 272..303", hs_lo, hs_hi);
    end
  endtask

  // Reduced instance: H_TOTAL=144, V_TOTAL=60, CLK_DIV=2 -> 17280 clks per frame.
  task automatic test_frame();
    int k, per, first_vb, vs_lo, vs_hi;
    for (int f = 0; f < 2; f++) begin
      k = 0;
      while (!s_fs && k < 20000) begin
        @(negedge clk);
        k++;
      end
      total++;
      if (!s_fs) begin
        bad++;
        $display("FAIL frame_start_timeout got none exp pulse");
      end
      per = 0; first_vb = -1; vs_lo = -1; vs_hi = -1;
      do begin
        @(negedge clk);
        per++;
        if (s_vb && first_vb < 0) first_vb = s_vc;
        if (s_vs) begin
          if (vs_lo < 0) vs_lo = s_vc;
          vs_hi = s_vc;
        end
      end while (!s_fs && per < 20000);
      total++;
      if (per !== 17280) begin
        bad++;
        $display("FAIL frame_period got %0d exp 17280", per);
      end
      total++;
      if (first_vb !== 48) begin
        bad++;
        $display("FAIL vblank_rise got %0d exp 48", first_vb);
      end
      total++;
      if (vs_lo !== 52 || vs_hi !== 54) begin
        bad++;
        $display("FAIL vsync_window got %0d..%0d exp 52..54", vs_lo, vs_hi);
      end
    end
  endtask

  task automatic test_csync_vsync();
    int k, errs, seen;
    bit exp_cs;
    k = 0;
    while (!(s_vc == 8'd52 && s_hc == 8'd0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    errs = 0; seen = 0;
    while (s_vc >= 8'd52 && s_vc <= 8'd54 && seen < 2000) begin
`ifdef ARCADE_CSYNC_XOR_EN
      exp_cs = (s_hc >= 8'd124 && s_hc <= 8'd131);
`else
      exp_cs = 1'b0;
`endif
      if (s_cs !== exp_cs) begin
        errs++;
        if (errs == 1) $display("FAIL csync_vsync hc=%0d vc=%0d got %b exp %b", s_hc, s_vc, s_cs, exp_cs);
      end
      seen++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (seen !== 864) begin
      bad++;
      $display("FAIL csync_vsync_span got %0d clks exp 864", seen);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    k = 0;
    while (!(s_hc == 8'd100 && s_vc == 8'd50) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!(s_hc == 8'd100 && s_vc == 8'd50)) begin
      bad++;
      $display("FAIL mid_reset_reach got hc=%0d vc=%0d exp 100 50", s_hc, s_vc);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({s_pix, s_hc, s_vc, s_hb, s_vb, s_de, s_hs, s_vs, s_cs, s_ls, s_fs} !==
        {1'b0, 8'd0, 8'd0, 8'b00100100}) begin
      bad++;
      $display("FAIL mid_reset_state got hc=%0d vc=%0d flags=%b exp 0 0 flags=00100100",
               s_hc, s_vc, {s_hb, s_vb, s_de, s_hs, s_vs, s_cs, s_ls, s_fs});
    end
    reset = 1'b0;
    k = 0;
    // no pulse may appear until the first full line has elapsed
    repeat (287) begin
      @(negedge clk);
      if (s_ls || s_fs || d_ls || d_fs) k++;
    end
    total++;
    if (k !== 0) begin
      bad++;
      $display("FAIL mid_reset_pulse got %0d early pulses exp 0", k);
    end
    @(negedge clk);
    total++;
    if (s_ls !== 1'b1 || s_fs !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_first_line got ls=%b fs=%b exp ls=1 fs=0", s_ls, s_fs);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_csync_vsync();
    test_mid_reset();
    repeat (4) @(negedge clk);
    total++;
    if (sb.size() > 1) begin
      bad++;
      $display("FAIL sb_drain got %0d pending exp <=1", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
